// File: rtl/soc_mem_arbiter.sv
// Arbitrates three requesters (loader, CPU data, CPU fetch) onto one single-port synchronous RAM.
// Every transaction takes IDLE -> ISSUE -> DONE; the loader has fixed priority and ports 1/2 alternate round robin.
module soc_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] winner;
  logic [1:0] pick;
  logic       last2;   // most recent grant among ports 1/2 went to port 2

  // Winner selection: loader first, then round robin between the CPU ports.
  always_comb begin
    pick = 2'd0;
    if (req[0])
      pick = 2'd0;
    else if (req[1] && req[2])
      pick = last2 ? 2'd1 : 2'd2;
    else if (req[1])
      pick = 2'd1;
    else if (req[2])
      pick = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ISSUE;
      ISSUE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once in IDLE and held through ISSUE and DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      winner    <= 2'd0;
      last2     <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == IDLE && (|req)) begin
      winner <= pick;
      if (pick != 2'd0)
        last2 <= (pick == 2'd2);
      case (pick)
        2'd1: begin
          mem_we    <= we[1];
          mem_addr  <= addr1;
          mem_wdata <= wdata1;
        end
        2'd2: begin
          mem_we    <= we[2];
          mem_addr  <= addr2;
          mem_wdata <= wdata2;
        end
        default: begin
          mem_we    <= we[0];
          mem_addr  <= addr0;
          mem_wdata <= wdata0;
        end
      endcase
    end
  end

  // Ack is masked by reset so an abandoned transaction never completes.
  always_comb begin
    mem_en = (state == ISSUE);
    busy   = (state != IDLE);
    rdata  = mem_rdata;
    ack    = 3'b000;
    if (state == DONE && !reset) begin
      case (winner)
        2'd1:    ack = 3'b010;
        2'd2:    ack = 3'b100;
        default: ack = 3'b001;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Directed bench for soc_mem_arbiter with a behavioural single-port RAM behind it.
module tb_soc_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [15:0] addr0, addr1, addr2;
  logic [7:0]  wdata0, wdata1, wdata2;
  logic [2:0]  ack;
  logic [7:0]  rdata;
  logic        busy;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [0:65535];

  int n_total = 0;
  int n_pass  = 0;

  soc_mem_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .addr2     (addr2),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .wdata2    (wdata2),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we)
        ram[mem_addr] <= mem_wdata;
      else
        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction from IDLE, checking ISSUE and DONE cycles.
  task automatic txn(input int p, input logic w, input logic [15:0] a,
                     input logic [7:0] d, input logic [7:0] exp_rd, input string tag);
    logic [2:0] oh;
    oh = 3'b001 << p;
    case (p)
      0: begin addr0 = a; wdata0 = d; end
      1: begin addr1 = a; wdata1 = d; end
      default: begin addr2 = a; wdata2 = d; end
    endcase
    we  = w ? oh : 3'b000;
    req = oh;
    check({tag, " idle ack"}, 32'(ack), 32'd0);
    tick();
    check({tag, " issue mem_en"}, 32'(mem_en), 32'd1);
    check({tag, " issue mem_addr"}, 32'(mem_addr), 32'(a));
    check({tag, " issue mem_we"}, 32'(mem_we), 32'(w));
    check({tag, " issue ack"}, 32'(ack), 32'd0);
    if (w) check({tag, " issue mem_wdata"}, 32'(mem_wdata), 32'(d));
    tick();
    check({tag, " done ack"}, 32'(ack), 32'(oh));
    check({tag, " done mem_en"}, 32'(mem_en), 32'd0);
    if (!w) check({tag, " done rdata"}, 32'(rdata), 32'(exp_rd));
    req = 3'b000;
    we  = 3'b000;
    tick();
    check({tag, " after ack"}, 32'(ack), 32'd0);
    check({tag, " after busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] exp_ack;
    ram[16'h0100] = 8'h5A;
    ram[16'h0020] = 8'h00;
    reset  = 1'b1;
    req    = 3'b111;
    we     = 3'b000;
    addr0  = 16'h0A00; addr1 = 16'h0011; addr2 = 16'h0022;
    wdata0 = 8'h00;    wdata1 = 8'h00;    wdata2 = 8'h00;

    // Reset held with all requests high.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst ack", 32'(ack), 32'd0);
      check("rst mem_en", 32'(mem_en), 32'd0);
      check("rst mem_addr", 32'(mem_addr), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
    end
    reset = 1'b0;
    req   = 3'b000;
    check("rel ack", 32'(ack), 32'd0);
    check("rel mem_en", 32'(mem_en), 32'd0);
    check("rel mem_addr", 32'(mem_addr), 32'd0);
    check("rel busy", 32'(busy), 32'd0);
    tick();

    // Full 1-vs-2 contention: port 1 first after reset, then alternating.
    req = 3'b110;
    for (int k = 0; k < 12; k++) begin
      case (k)
        2, 8:    exp_ack = 3'b010;
        5, 11:   exp_ack = 3'b100;
        default: exp_ack = 3'b000;
      endcase
      check($sformatf("cont ack k=%0d", k), 32'(ack), 32'(exp_ack));
      if (k % 3 == 1)
        check($sformatf("cont addr k=%0d", k), 32'(mem_addr),
              (k % 6 == 1) ? 32'h0011 : 32'h0022);
      tick();
    end
    req = 3'b000;
    tick();

    // Loader priority, then 1/2 alternation resumes with port 1.
    req = 3'b111;
    for (int k = 0; k < 15; k++) begin
      if (k == 9) req = 3'b110;
      case (k)
        2, 5, 8: exp_ack = 3'b001;
        11:      exp_ack = 3'b010;
        14:      exp_ack = 3'b100;
        default: exp_ack = 3'b000;
      endcase
      check($sformatf("prio ack k=%0d", k), 32'(ack), 32'(exp_ack));
      if (k == 1) check("prio addr", 32'(mem_addr), 32'h0A00);
      tick();
    end
    req = 3'b000;
    tick();

    txn(2, 1'b0, 16'h0100, 8'h00, 8'h5A, "rd2");
    txn(1, 1'b1, 16'h0020, 8'h3C, 8'h00, "wr1");
    txn(1, 1'b0, 16'h0020, 8'h00, 8'h3C, "rd1");

    // Reset asserted in the DONE cycle of a port-2 read.
    addr2 = 16'h0100;
    req   = 3'b100;
    tick();
    check("mid issue mem_en", 32'(mem_en), 32'd1);
    tick();
    reset = 1'b1;
    req   = 3'b000;
    #1;
    check("mid done ack", 32'(ack), 32'd0);
    tick();
    reset = 1'b0;
    check("mid post ack", 32'(ack), 32'd0);
    check("mid post busy", 32'(busy), 32'd0);
    check("mid post mem_en", 32'(mem_en), 32'd0);
    tick();
    txn(1, 1'b0, 16'h0020, 8'h00, 8'h3C, "post");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
